tape_fsk_player: RTL and testbench

TAPE_FSK_PLAYER -- requirements
Module: tape_fsk_player

---
 rtl/tape_fsk_player.sv | 218 +++++++++++++++++++++
 tb/tb_tape_fsk_player.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_fsk_player.sv
// Cassette-tape FSK player: prefetches tape bytes from memory into a small FIFO
// and shifts them out LSB first as Kansas-City style square waves.
module tape_fsk_player #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HALF0      = 23864,
  parameter int unsigned HALF1      = 11932,
  parameter int unsigned MOTOR_GATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              rewind,
  input  logic              motor,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  output logic              data,
  output logic              running,
  output logic              eot,
  output logic [ADDR_W-1:0] position
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW   = PTR_W + 1;
  localparam int unsigned HALF_MAX = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int unsigned CNT_W    = $clog2(HALF_MAX + 1);

  localparam logic [0:0] F_IDLE = 1'b0;
  localparam logic [0:0] F_REQ  = 1'b1;

  logic [0:0]        fetch_state_q, fetch_state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              discard_q, discard_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bit_q, bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              started_q, started_d;
  logic              data_q, data_d;
  logic              running_q, running_d;
  logic              eot_q, eot_d;
  logic [ADDR_W-1:0] position_q, position_d;

  logic              adv_c, fifo_empty_c, fifo_full_c, half_end_c, byte_end_c;
  logic              push_c, pop_c;
  logic [CNT_W-1:0]  half_c;

  assign mem_rd   = fetch_state_q[0];
  assign mem_addr = fetch_addr_q;
  assign data     = data_q;
  assign running  = running_q;
  assign eot      = eot_q;
  assign position = position_q;

  assign adv_c        = running_q && ((MOTOR_GATE == 0) || motor);
  assign fifo_empty_c = (count_q == '0);
  assign fifo_full_c  = (count_q == CNT_FW'(FIFO_DEPTH));
  assign half_c       = sh_q[0] ? CNT_W'(HALF1 - 1) : CNT_W'(HALF0 - 1);
  assign half_end_c   = (cnt_q == half_c);

  always_comb begin
    fetch_state_d = fetch_state_q;
    fetch_addr_d  = fetch_addr_q;
    discard_d     = discard_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    sh_d          = sh_q;
    bit_d         = bit_q;
    cnt_d         = cnt_q;
    active_d      = active_q;
    started_d     = started_q;
    data_d        = data_q;
    running_d     = running_q;
    eot_d         = eot_q;
    position_d    = position_q;
    push_c        = 1'b0;
    pop_c         = 1'b0;
    byte_end_c    = 1'b0;

    // Fetcher: one outstanding read; a read orphaned by rewind is dropped on completion
    unique case (fetch_state_q)
      F_IDLE: begin
        if (running_q && !rewind && !fifo_full_c && (fetch_addr_q < tape_len))
          fetch_state_d = F_REQ;
      end
      default: begin
        if (mem_valid) begin
          fetch_state_d = F_IDLE;
          discard_d     = 1'b0;
          if (!discard_q) begin
            push_c       = 1'b1;
            fetch_addr_d = ADDR_W'(fetch_addr_q + 1'b1);
          end
        end
      end
    endcase

    if (play) begin
      if (running_q) running_d = 1'b0;
      else if (!eot_q) begin
        if (tape_len != '0) running_d = 1'b1;
        else                eot_d     = 1'b1;
      end
    end

    // Serializer: data level doubles as the half-period phase (1 = high half)
    if (adv_c) begin
      if (active_q) begin
        if (half_end_c) begin
          cnt_d = '0;
          if (data_q) data_d = 1'b0;
          else if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            sh_d   = {1'b0, sh_q[7:1]};
            data_d = 1'b1;
          end else byte_end_c = 1'b1;
        end else cnt_d = CNT_W'(cnt_q + 1'b1);
      end
      if (!active_q || byte_end_c) begin
        if (!fifo_empty_c) begin
          pop_c      = 1'b1;
          sh_d       = fifo_q[rd_ptr_q];
          bit_d      = 3'd0;
          cnt_d      = '0;
          data_d     = 1'b1;
          active_d   = 1'b1;
          started_d  = 1'b1;
          position_d = started_q ? ADDR_W'(position_q + 1'b1) : position_q;
        end else begin
          active_d = 1'b0;
          data_d   = 1'b0;
          if ((fetch_state_q == F_IDLE) && !(fetch_addr_q < tape_len)) begin
            eot_d     = 1'b1;
            running_d = 1'b0;
          end
        end
      end
    end

    if (rewind) begin
      push_c       = 1'b0;
      pop_c        = 1'b0;
      fetch_addr_d = '0;
      discard_d    = (fetch_state_q == F_REQ) && !mem_valid;
      position_d   = '0;
      started_d    = 1'b0;
      active_d     = 1'b0;
      sh_d         = '0;
      bit_d        = 3'd0;
      cnt_d        = '0;
      data_d       = 1'b0;
      running_d    = 1'b0;
      eot_d        = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end

    if (push_c) begin
      fifo_d[wr_ptr_q] = mem_data;
      wr_ptr_d         = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (pop_c) rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    unique case ({push_c, pop_c})
      2'b10:   count_d = CNT_FW'(count_q + 1'b1);
      2'b01:   count_d = CNT_FW'(count_q - 1'b1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_state_q <= F_IDLE;
      fetch_addr_q  <= '0;
      discard_q     <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sh_q          <= '0;
      bit_q         <= 3'd0;
      cnt_q         <= '0;
      active_q      <= 1'b0;
      started_q     <= 1'b0;
      data_q        <= 1'b0;
      running_q     <= 1'b0;
      eot_q         <= 1'b0;
      position_q    <= '0;
    end else begin
      fetch_state_q <= fetch_state_d;
      fetch_addr_q  <= fetch_addr_d;
      discard_q     <= discard_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      sh_q          <= sh_d;
      bit_q         <= bit_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      started_q     <= started_d;
      data_q        <= data_d;
      running_q     <= running_d;
      eot_q         <= eot_d;
      position_q    <= position_d;
    end
  end

endmodule

// File: tb/tb_tape_fsk_player.sv
// Directed bench for tape_fsk_player with a variable-latency memory responder.
module tb_tape_fsk_player;

  logic        clk = 1'b0;
  logic        reset, play, rewind, motor;
  logic [15:0] tape_len, mem_addr, position;
  logic        mem_rd, mem_valid, data, running, eot;
  logic [7:0]  mem_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tape [16];
  int         mem_lat = 3;
  int         rd_count = 0;
  bit         inject = 1'b0;
  bit         busy = 1'b0;
  int         lat_cnt = 0;
  logic [3:0] req_addr = '0;

  bit   cap_en = 1'b0;
  logic wave_q [$];
  logic exp_q  [$];

  tape_fsk_player #(
    .ADDR_W(16), .FIFO_DEPTH(4), .HALF0(4), .HALF1(2), .MOTOR_GATE(1)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .rewind(rewind), .motor(motor),
    .tape_len(tape_len), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_valid(mem_valid), .data(data),
    .running(running), .eot(eot), .position(position)
  );

  always #5 clk = ~clk;

  // Memory responder: latches the request, answers mem_lat negedges later
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (!reset) busy = 1'b0;
    else if (inject) begin
      mem_valid = 1'b1;
      mem_data  = 8'hEE;
      inject    = 1'b0;
    end else if (busy) begin
      if (lat_cnt <= 1) begin
        mem_valid = 1'b1;
        mem_data  = tape[req_addr];
        busy      = 1'b0;
      end else lat_cnt--;
    end else if (mem_rd) begin
      busy     = 1'b1;
      lat_cnt  = mem_lat;
      req_addr = mem_addr[3:0];
      rd_count++;
    end
  end

  always @(negedge clk) if (cap_en) wave_q.push_back(data);

  task automatic pulse_play();
    @(negedge clk) play = 1'b1;
    @(negedge clk) play = 1'b0;
  endtask

  task automatic pulse_rewind();
    @(negedge clk) rewind = 1'b1;
    @(negedge clk) rewind = 1'b0;
  endtask

  task automatic start_capture();
    wave_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic wait_rd(input logic level, input int max);
    int t = 0;
    while (mem_rd !== level && t < max) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Expected waveform of one byte; `extra` stretches the first high half
  task automatic build_exp(input logic [7:0] b, input int extra, input int tail);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      int h = b[i] ? 2 : 4;
      for (int k = 0; k < h + ((i == 0) ? extra : 0); k++) exp_q.push_back(1'b1);
      for (int k = 0; k < h; k++) exp_q.push_back(1'b0);
    end
    for (int k = 0; k < tail; k++) exp_q.push_back(1'b0);
  endtask

  function automatic int first_one();
    for (int i = 0; i < wave_q.size(); i++) if (wave_q[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_rd, data, running, eot} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: {rd,data,run,eot}=%b expected 0000", {mem_rd, data, running, eot});
    end
    n_checks++;
    if (mem_addr !== 16'd0 || position !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_addr: addr=%0d pos=%0d expected 0 0", mem_addr, position);
    end
    tape_len = 16'd4;
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (mem_rd !== 1'b0 || running !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_paused: rd=%b running=%b expected 0 0", mem_rd, running);
    end
  endtask

  task automatic test_single_byte();
    int idx, errs;
    tape[0] = 8'h01; tape_len = 16'd1; mem_lat = 3;
    pulse_rewind();
    rd_count = 0;
    start_capture();
    pulse_play();
    repeat (90) @(negedge clk);
    cap_en = 1'b0;
    build_exp(8'h01, 0, 4);
    idx = first_one(); errs = 0;
    if (idx < 0 || idx + exp_q.size() > wave_q.size()) errs = 1;
    else for (int i = 0; i < exp_q.size(); i++) if (wave_q[idx+i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0) begin
      n_errors++;
      $display("FAIL single_wave: %0d bad samples (start %0d of %0d) expected 0", errs, idx, wave_q.size());
    end
    n_checks++;
    if (eot !== 1'b1 || running !== 1'b0) begin
      n_errors++;
      $display("FAIL single_eot: eot=%b running=%b expected 1 0", eot, running);
    end
    n_checks++;
    if (rd_count != 1) begin
      n_errors++;
      $display("FAIL single_reads: %0d reads expected 1", rd_count);
    end
  endtask

  task automatic test_prefetch();
    int t;
    for (int i = 0; i < 8; i++) tape[i] = 8'h00;
    tape_len = 16'd8;
    pulse_rewind();
    rd_count = 0;
    pulse_play();
    t = 0;
    while (data !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    n_checks++;
    if (data !== 1'b1) begin
      n_errors++;
      $display("FAIL prefetch_start: data=%b expected 1 within 40 clocks", data);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 16'd5 || rd_count != 5) begin
      n_errors++;
      $display("FAIL prefetch_full: rd=%b addr=%0d reads=%0d expected 0 5 5", mem_rd, mem_addr, rd_count);
    end
    wait_rd(1'b1, 40);
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'd5) begin
      n_errors++;
      $display("FAIL prefetch_refill: rd=%b addr=%0d expected 1 5", mem_rd, mem_addr);
    end
  endtask

  task automatic test_motor();
    int idx, errs, t;
    tape[0] = 8'h00; tape_len = 16'd1;
    pulse_rewind();
    start_capture();
    pulse_play();
    t = 0;
    while (data !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    @(negedge clk) motor = 1'b0;
    repeat (10) @(negedge clk);
    motor = 1'b1;
    repeat (80) @(negedge clk);
    cap_en = 1'b0;
    build_exp(8'h00, 10, 4);
    idx = first_one(); errs = 0;
    if (idx < 0 || idx + exp_q.size() > wave_q.size()) errs = 1;
    else for (int i = 0; i < exp_q.size(); i++) if (wave_q[idx+i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0) begin
      n_errors++;
      $display("FAIL motor_wave: %0d bad samples (start %0d of %0d) expected 0", errs, idx, wave_q.size());
    end
  endtask

  task automatic test_rewind_fetch();
    int idx, errs;
    tape[0] = 8'hA5;
    for (int i = 1; i < 8; i++) tape[i] = 8'h3C;
    tape_len = 16'd8;
    pulse_rewind();
    pulse_play();
    repeat (12) @(negedge clk);
    wait_rd(1'b0, 10);
    wait_rd(1'b1, 10);
    rewind = 1'b1;
    @(negedge clk) rewind = 1'b0;
    n_checks++;
    if ({mem_rd, running, data, eot} !== 4'b1000 || position !== 16'd0) begin
      n_errors++;
      $display("FAIL rewind_state: {rd,run,data,eot}=%b pos=%0d expected 1000 0", {mem_rd, running, data, eot}, position);
    end
    wait_rd(1'b0, 10);
    repeat (3) @(negedge clk);
    n_checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 16'd0) begin
      n_errors++;
      $display("FAIL rewind_drop: rd=%b addr=%0d expected 0 0", mem_rd, mem_addr);
    end
    start_capture();
    pulse_play();
    repeat (70) @(negedge clk);
    build_exp(8'hA5, 0, 0);
    idx = first_one(); errs = 0;
    if (idx < 0 || idx + exp_q.size() > wave_q.size()) errs = 1;
    else for (int i = 0; i < exp_q.size(); i++) if (wave_q[idx+i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0) begin
      n_errors++;
      $display("FAIL rewind_restart: %0d bad samples in byte 0 expected 0", errs);
    end
  endtask

  task automatic test_play_rewind();
    int idx, errs;
    repeat (100) @(negedge clk);
    n_checks++;
    if (running !== 1'b1 || position == 16'd0) begin
      n_errors++;
      $display("FAIL pr_progress: running=%b pos=%0d expected 1 nonzero", running, position);
    end
    play = 1'b1; rewind = 1'b1;
    @(negedge clk) begin play = 1'b0; rewind = 1'b0; end
    repeat (10) @(negedge clk);
    n_checks++;
    if (running !== 1'b0 || position !== 16'd0 || data !== 1'b0) begin
      n_errors++;
      $display("FAIL pr_rewind_wins: running=%b pos=%0d data=%b expected 0 0 0", running, position, data);
    end
    start_capture();
    pulse_play();
    repeat (70) @(negedge clk);
    cap_en = 1'b0;
    build_exp(8'hA5, 0, 0);
    idx = first_one(); errs = 0;
    if (idx < 0 || idx + exp_q.size() > wave_q.size()) errs = 1;
    else for (int i = 0; i < exp_q.size(); i++) if (wave_q[idx+i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0) begin
      n_errors++;
      $display("FAIL pr_restart: %0d bad samples in byte 0 expected 0", errs);
    end
  endtask

  task automatic test_underrun();
    int idx, t, run, n_high, bad_high, bad_low, gaps;
    logic cur;
    for (int i = 0; i < 3; i++) tape[i] = 8'h00;
    tape_len = 16'd3; mem_lat = 80;
    pulse_rewind();
    start_capture();
    pulse_play();
    t = 0;
    while (eot !== 1'b1 && t < 800) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    cap_en = 1'b0;
    mem_lat = 3;
    n_checks++;
    if (eot !== 1'b1) begin
      n_errors++;
      $display("FAIL underrun_eot: eot=%b expected 1 within 800 clocks", eot);
    end
    idx = first_one();
    n_high = 0; bad_high = 0; bad_low = 0; gaps = 0; run = 0; cur = 1'b1;
    if (idx >= 0) begin
      for (int i = idx; i < wave_q.size(); i++) begin
        if (wave_q[i] === cur) run++;
        else begin
          if (cur) begin n_high++; if (run != 4) bad_high++; end
          else begin if (run < 4) bad_low++; if (run > 4) gaps++; end
          cur = wave_q[i];
          run = 1;
        end
      end
    end
    n_checks++;
    if (n_high != 24 || bad_high != 0) begin
      n_errors++;
      $display("FAIL underrun_high: %0d high halves (%0d not 4 clocks) expected 24 (0)", n_high, bad_high);
    end
    n_checks++;
    if (bad_low != 0 || gaps != 2) begin
      n_errors++;
      $display("FAIL underrun_low: %0d short lows, %0d gaps expected 0, 2", bad_low, gaps);
    end
  endtask

  task automatic test_empty_tape();
    tape_len = 16'd0;
    pulse_rewind();
    pulse_play();
    repeat (3) @(negedge clk);
    n_checks++;
    if (running !== 1'b0 || eot !== 1'b1 || mem_rd !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_play: running=%b eot=%b rd=%b expected 0 1 0", running, eot, mem_rd);
    end
    pulse_rewind();
    n_checks++;
    if (eot !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_rewind: eot=%b expected 0", eot);
    end
  endtask

  task automatic test_reset_midfetch();
    tape_len = 16'd8;
    pulse_rewind();
    pulse_play();
    wait_rd(1'b1, 20);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_rd, running, data} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_async: {rd,run,data}=%b expected 000", {mem_rd, running, data});
    end
    @(negedge clk) reset = 1'b1;
    inject = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (mem_addr !== 16'd0 || mem_rd !== 1'b0 || running !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_stray: addr=%0d rd=%b running=%b expected 0 0 0", mem_addr, mem_rd, running);
    end
  endtask

  initial begin
    reset = 1'b0; play = 1'b0; rewind = 1'b0; motor = 1'b1; tape_len = '0;
    for (int i = 0; i < 16; i++) tape[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_prefetch();
    test_motor();
    test_rewind_fetch();
    test_play_rewind();
    test_underrun();
    test_empty_tape();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
